// File: rtl/ram_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the RAM write arbiter and its pickers.
package ram_ctrl_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATAWIDTH_DEF = 8;
  localparam int ADDRWIDTH_DEF = 3;

  // Pointer width for a round-robin index over n requesters; never below one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_wr_arbiter_if.sv
// Requester handshake, clear control and the two RAM write ports.
interface ram_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 3
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ADDRWIDTH-1:0] req_addr;
  logic [NUM_REQ*DATAWIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         clr_req;
  logic                         clr_busy;
  logic                         clr_done;
  logic                         en_w1_n;
  logic [ADDRWIDTH-1:0]         addr_w1;
  logic [DATAWIDTH-1:0]         data_w1;
  logic                         en_w2_n;
  logic [ADDRWIDTH-1:0]         addr_w2;
  logic [DATAWIDTH-1:0]         data_w2;

  modport master (
    output req_valid, req_addr, req_data, clr_req,
    input  req_ready, clr_busy, clr_done,
           en_w1_n, addr_w1, data_w1, en_w2_n, addr_w2, data_w2
  );

  modport slave (
    input  req_valid, req_addr, req_data, clr_req,
    output req_ready, clr_busy, clr_done,
           en_w1_n, addr_w1, data_w1, en_w2_n, addr_w2, data_w2
  );
endinterface

// File: rtl/ram_wr_arbiter_rr_pick.sv
// Cyclic find-first-set: lowest set bit of mask at or after ptr, wrapping.
module ram_rr_pick
  import ram_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && mask[j]) begin
        found = 1'b1;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_wr_arbiter.sv
// Round-robin arbiter for the two RAM write ports, plus a two-words-per-cycle zero-fill.
//   state    | meaning
//   ST_ARB   | grant up to two distinct-address writes per cycle
//   ST_CLEAR | write zeros to pair clr_cnt, requesters held off
module ram_wr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int ADDRWIDTH = ADDRWIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  ram_wr_arbiter_if.slave  bus
);

  localparam int PW = ptr_width(NUM_REQ);
  localparam logic [ADDRWIDTH-1:0] CLR_LAST = ADDRWIDTH'(2**(ADDRWIDTH-1) - 1);

  state_t               state;
  logic [PW-1:0]        rr_ptr;
  logic [ADDRWIDTH-1:0] clr_cnt;
  logic [ADDRWIDTH-1:0] clr_nxt;
  logic                 g0_found, g1_found;
  logic [PW-1:0]        g0_idx, g1_idx, g1_ptr;
  logic [NUM_REQ-1:0]   mask1;
  logic [ADDRWIDTH-1:0] g0_addr, g1_addr;
  logic [DATAWIDTH-1:0] g0_data, g1_data;
  logic                 arb_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  ram_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick0 (
    .mask  (bus.req_valid),
    .ptr   (rr_ptr),
    .found (g0_found),
    .idx   (g0_idx)
  );

  assign g0_addr = bus.req_addr[int'(g0_idx)*ADDRWIDTH +: ADDRWIDTH];
  assign g0_data = bus.req_data[int'(g0_idx)*DATAWIDTH +: DATAWIDTH];
  assign g1_ptr  = ptr_inc(g0_idx);

  // Second candidate must not target g0's address; those requesters simply wait.
  always_comb begin
    mask1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask1[i] = bus.req_valid[i] && (i != int'(g0_idx)) &&
                 (bus.req_addr[i*ADDRWIDTH +: ADDRWIDTH] != g0_addr);
    end
  end

  ram_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick1 (
    .mask  (mask1),
    .ptr   (g1_ptr),
    .found (g1_found),
    .idx   (g1_idx)
  );

  assign g1_addr = bus.req_addr[int'(g1_idx)*ADDRWIDTH +: ADDRWIDTH];
  assign g1_data = bus.req_data[int'(g1_idx)*DATAWIDTH +: DATAWIDTH];

  assign arb_en  = !rst && (state == ST_ARB) && !bus.clr_req;
  assign clr_nxt = clr_cnt + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (arb_en && g0_found) begin
      bus.req_ready[g0_idx] = 1'b1;
      if (g1_found) bus.req_ready[g1_idx] = 1'b1;
    end
  end

  assign bus.clr_busy = (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ARB;
      rr_ptr       <= '0;
      clr_cnt      <= '0;
      bus.clr_done <= 1'b0;
      bus.en_w1_n  <= 1'b1;
      bus.en_w2_n  <= 1'b1;
      bus.addr_w1  <= '0;
      bus.addr_w2  <= '0;
      bus.data_w1  <= '0;
      bus.data_w2  <= '0;
    end else begin
      bus.clr_done <= 1'b0;
      case (state)
        ST_ARB: begin
          if (bus.clr_req) begin
            state        <= ST_CLEAR;
            clr_cnt      <= '0;
            bus.en_w1_n  <= 1'b0;
            bus.en_w2_n  <= 1'b0;
            bus.addr_w1  <= '0;
            bus.addr_w2  <= ADDRWIDTH'(1);
            bus.data_w1  <= '0;
            bus.data_w2  <= '0;
            bus.clr_done <= (CLR_LAST == '0);
          end else begin
            bus.en_w1_n <= !g0_found;
            bus.en_w2_n <= !g1_found;
            if (g0_found) begin
              bus.addr_w1 <= g0_addr;
              bus.data_w1 <= g0_data;
              rr_ptr      <= g1_found ? ptr_inc(g1_idx) : ptr_inc(g0_idx);
            end
            if (g1_found) begin
              bus.addr_w2 <= g1_addr;
              bus.data_w2 <= g1_data;
            end
          end
        end
        ST_CLEAR: begin
          // The pair for clr_cnt is already on the ports; load the next or finish.
          if (clr_cnt == CLR_LAST) begin
            state       <= ST_ARB;
            bus.en_w1_n <= 1'b1;
            bus.en_w2_n <= 1'b1;
          end else begin
            clr_cnt      <= clr_nxt;
            bus.addr_w1  <= clr_nxt << 1;
            bus.addr_w2  <= (clr_nxt << 1) | ADDRWIDTH'(1);
            bus.data_w1  <= '0;
            bus.data_w2  <= '0;
            bus.clr_done <= (clr_nxt == CLR_LAST);
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Scoreboard bench for ram_wr_arbiter: directed scenarios then randomized traffic.
module tb_ram_wr_arbiter;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int HALF = (1 << AW) / 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_wr_arbiter_if #(.NUM_REQ(N), .DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

  ram_wr_arbiter #(.NUM_REQ(N), .DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit en1; int a1; int d1;
    bit en2; int a2; int d2;
    bit done;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  bit  pend[N];
  int  p_addr[N];
  int  p_data[N];
  bit  granted[N];
  int  wait_cnt[N];
  int  max_wait = 0;
  int  m_ptr = 0;
  int  clr_left = 0;
  bit  clr_pulse = 1'b0;
  bit  refill = 1'b0;
  bit  rst_nxt = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]             = pend[i];
      bus.req_addr[i*AW +: AW]     = AW'(p_addr[i]);
      bus.req_data[i*DW +: DW]     = DW'(p_data[i]);
    end
    bus.clr_req = clr_pulse;
  endtask

  // Reference: grants follow the round-robin rule over the pending set.
  task automatic model_eval();
    int order[$];
    int g0, g1;
    logic [N-1:0] er;
    wr_t e;
    g0 = -1; g1 = -1; er = '0;
    for (int i = 0; i < N; i++) granted[i] = 1'b0;
    if (rst) begin
      chk("ready_in_reset", bus.req_ready, 0);
      exp_q.delete();
      m_ptr = 0;
      clr_left = 0;
    end else if (clr_left > 0) begin
      chk("ready_in_clear", bus.req_ready, 0);
      chk("clr_busy_clear", bus.clr_busy, 1);
      clr_left--;
    end else if (clr_pulse) begin
      chk("ready_on_clr_req", bus.req_ready, 0);
      chk("clr_busy_idle", bus.clr_busy, 0);
      for (int k = 0; k < HALF; k++) begin
        e = '{en1: 1'b1, a1: 2*k, d1: 0, en2: 1'b1, a2: 2*k+1, d2: 0, done: (k == HALF-1)};
        exp_q.push_back(e);
      end
      clr_left = HALF;
    end else begin
      chk("clr_busy_arb", bus.clr_busy, 0);
      for (int k = 0; k < N; k++)
        if (pend[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
      if (order.size() > 0) begin
        g0 = order[0];
        for (int k = 1; k < order.size(); k++)
          if (g1 < 0 && p_addr[order[k]] != p_addr[g0]) g1 = order[k];
      end
      if (g0 >= 0) er[g0] = 1'b1;
      if (g1 >= 0) er[g1] = 1'b1;
      chk("req_ready", bus.req_ready, er);
      if (g0 >= 0) begin
        e = '{en1: 1'b1, a1: p_addr[g0], d1: p_data[g0], en2: (g1 >= 0),
              a2: (g1 >= 0) ? p_addr[g1] : 0, d2: (g1 >= 0) ? p_data[g1] : 0, done: 1'b0};
        exp_q.push_back(e);
        granted[g0] = 1'b1;
        if (g1 >= 0) granted[g1] = 1'b1;
        m_ptr = (((g1 >= 0) ? g1 : g0) + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (pend[i] && !granted[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  task automatic run_cycle(input bit rnd);
    @(posedge clk);
    #2;
    rst = rst_nxt;
    for (int i = 0; i < N; i++) begin
      if (granted[i]) begin
        pend[i] = 1'b0;
        if (refill) begin
          pend[i]   = 1'b1;
          p_addr[i] = 2 * i;
          p_data[i] = int'($urandom_range(0, 255));
        end
      end
      if (rnd && !pend[i] && $urandom_range(0, 99) < 40) begin
        pend[i]   = 1'b1;
        p_addr[i] = int'($urandom_range(0, (1 << AW) - 1));
        p_data[i] = int'($urandom_range(0, 255));
      end
    end
    if (rnd) clr_pulse = ($urandom_range(0, 59) == 0);
    drive();
    @(negedge clk);
    model_eval();
  endtask

  task automatic set_req(input int i, input int a, input int d);
    pend[i] = 1'b1; p_addr[i] = a; p_data[i] = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en_w1_n"}, bus.en_w1_n, 1);
    chk({tag, "_en_w2_n"}, bus.en_w2_n, 1);
    chk({tag, "_clr_busy"}, bus.clr_busy, 0);
    chk({tag, "_clr_done"}, bus.clr_done, 0);
  endtask

  // Monitor: every cycle where a write is due or the DUT shows one, match it.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (bus.en_w1_n === 1'b0 || bus.en_w2_n === 1'b0 || exp_q.size() != 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {bus.en_w1_n, bus.en_w2_n}, 2'b11);
      end else begin
        e = exp_q.pop_front();
        chk("en_w1_n", bus.en_w1_n, !e.en1);
        chk("addr_w1", bus.addr_w1, e.a1);
        chk("data_w1", bus.data_w1, e.d1);
        chk("en_w2_n", bus.en_w2_n, !e.en2);
        if (e.en2) begin
          chk("addr_w2", bus.addr_w2, e.a2);
          chk("data_w2", bus.data_w2, e.d2);
        end
        chk("clr_done", bus.clr_done, e.done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int npend;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_req(i, 2 * i, 16 + i);
      wait_cnt[i] = 0;
      granted[i]  = 1'b0;
    end
    drive();

    // Reset with every requester valid
    run_cycle(0);
    run_cycle(0);
    chk_reset_outputs("reset");
    chk("reset_addr_w1", bus.addr_w1, 0);
    chk("reset_data_w2", bus.data_w2, 0);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    rst_nxt = 1'b0;
    run_cycle(0);

    // Single grant
    set_req(0, 3, 8'hA5);
    run_cycle(0);
    run_cycle(0);
    // Move pointer to 0, then dual grant
    set_req(3, 7, 8'h33);
    run_cycle(0);
    run_cycle(0);
    set_req(0, 1, 8'h11);
    set_req(2, 5, 8'h22);
    run_cycle(0);
    run_cycle(0);
    // Pointer to 1, then same-address collision between 1 and 3
    set_req(0, 0, 8'h44);
    run_cycle(0);
    run_cycle(0);
    set_req(1, 4, 8'h55);
    set_req(3, 4, 8'h66);
    run_cycle(0);
    run_cycle(0);
    run_cycle(0);

    // Fairness with all four continuously valid
    for (int i = 0; i < N; i++) set_req(i, 2 * i, 8'h80 + i);
    refill = 1'b1;
    repeat (4) run_cycle(0);
    refill = 1'b0;
    repeat (3) run_cycle(0);

    // Full clear, a pending requester waiting, and a clr_req ignored mid-clear
    set_req(1, 2, 8'h77);
    clr_pulse = 1'b1;
    run_cycle(0);
    clr_pulse = 1'b0;
    run_cycle(0);
    clr_pulse = 1'b1;
    run_cycle(0);
    clr_pulse = 1'b0;
    repeat (5) run_cycle(0);

    // Reset during the second clear cycle
    clr_pulse = 1'b1;
    run_cycle(0);
    clr_pulse = 1'b0;
    run_cycle(0);
    rst_nxt = 1'b1;
    run_cycle(0);
    rst_nxt = 1'b0;
    run_cycle(0);
    chk_reset_outputs("reset_mid_clear");
    run_cycle(0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) run_cycle(1);
    clr_pulse = 1'b0;

    cnt = 0;
    npend = N;
    while (cnt < 200 && (npend != 0 || clr_left != 0)) begin
      run_cycle(0);
      npend = 0;
      for (int i = 0; i < N; i++) if (pend[i] && !granted[i]) npend++;
      cnt++;
    end
    chk("drain_pending", npend, 0);
    run_cycle(0);
    run_cycle(0);
    chk("queue_empty", exp_q.size(), 0);
    chk("starvation_bound", (max_wait > 200), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_wr_arbiter.md
Name: ram_wr_arbiter

Overview:
Shares the two write ports of the dual-write/dual-read flip-flop RAM among NUM_REQ requesters, using a round-robin valid/ready handshake.
Grants up to two writes per cycle and never issues the same address on both ports in one cycle.
Also provides a clear sequencer that zero-fills the whole RAM two words per cycle on request.
Sits directly in front of the RAM write ports; the read ports are not touched.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATAWIDTH, 8, RAM word width
ADDRWIDTH, 3, RAM address width; depth = 2**ADDRWIDTH (always even)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester write request
req_addr  in  NUM_REQ*ADDRWIDTH  packed addresses, requester i at [i*ADDRWIDTH +: ADDRWIDTH]
req_data  in  NUM_REQ*DATAWIDTH  packed data, same packing
req_ready  out  NUM_REQ  combinational grant; transfer occurs when valid&&ready
clr_req  in  1  one-cycle pulse that starts a full clear
clr_busy  out  1  high while clearing
clr_done  out  1  one-cycle pulse coincident with the final clear write
en_w1_n  out  1  RAM write port 1 enable, active-low, registered
addr_w1  out  ADDRWIDTH  registered
data_w1  out  DATAWIDTH  registered
en_w2_n  out  1  RAM write port 2 enable, active-low, registered
addr_w2  out  ADDRWIDTH  registered
data_w2  out  DATAWIDTH  registered

Behaviour:
- Reset (rst=1 at posedge): state=ST_ARB, rr_ptr=0, en_w1_n=en_w2_n=1, addr/data outputs=0, clr_busy=0, clr_done=0. req_ready=0 while rst=1.
- Protocol: once asserted, a requester holds valid/addr/data stable until ready. The arbiter never drops a held request.
- ST_ARB, with no clr_req:
  - g0 = first valid index at or after rr_ptr, cyclic.
  - g1 = next valid index after g0, cyclic, with req_addr[g1] != req_addr[g0].
  - Requesters skipped because their address matches g0 stay pending and are not ready.
- req_ready[g0], req_ready[g1] = 1; all others 0.
- Latency is 1 cycle: at the next posedge, port 1 takes g0's addr/data with en_w1_n=0, and port 2 takes g1's with en_w2_n=0.
- Single grant: port 1 only, en_w2_n=1. No grant: both enables=1, addr/data hold their previous values.
- rr_ptr update: rr_ptr <= (last granted index + 1) mod NUM_REQ. Last granted is g1 if it exists, otherwise g0. rr_ptr is unchanged when nothing is granted.
- clr_req in ST_ARB: wins over all requests that cycle (req_ready=0). Next state is ST_CLEAR, clr_cnt=0.
- ST_CLEAR:
  - req_ready=0 and clr_busy=1.
  - Each cycle, the registered outputs write addr_w1=2*clr_cnt and addr_w2=2*clr_cnt+1, both data=0, both enables low.
  - clr_cnt counts 0..2**(ADDRWIDTH-1)-1. On the final pair, clr_done=1 for that cycle and the state returns to ST_ARB.
  - clr_req during ST_CLEAR is ignored.
  - rr_ptr is preserved across the clear.
- Reset mid-clear: aborts immediately to reset values; clr_done is not pulsed.
- The write ports never carry equal addresses with both enables low.

Decomposition:
- Package ram_ctrl_pkg holds:
  - state_t enum {ST_ARB, ST_CLEAR}
  - localparam helper for clog2(NUM_REQ) pointer width
- Sub-module ram_rr_pick: combinational find-first-set in a request mask starting at a pointer, cyclic. Outputs found and idx.
  - Instantiated twice: once for g0, once for g1 with the mask excluding g0 and all same-address requesters.
- Top level holds the FSM, rr_ptr, clr_cnt and the output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, en_w1_n=en_w2_n=1, clr_busy=0.
- Single: req0 valid, addr=3, data=0xA5 -> ready0=1 the same cycle; next cycle en_w1_n=0, addr_w1=3, data_w1=0xA5, en_w2_n=1; rr_ptr=1.
- Dual: rr_ptr=0, req0 (addr 1, 0x11) and req2 (addr 5, 0x22) -> both ready; next cycle w1=(1,0x11), w2=(5,0x22); rr_ptr=3.
- Collision: req1 and req3 both addr 4, rr_ptr=1 -> only ready1. req3 is granted on the following cycle on w1 with en_w2_n=1.
- Fairness: all 4 valid continuously, distinct addresses -> grant pairs (0,1),(2,3),(0,1),(2,3) over 4 cycles; no requester starves.
- Clear: ADDRWIDTH=3, pulse clr_req -> 4 cycles of writes (0,1),(2,3),(4,5),(6,7), all data 0; clr_done high with (6,7); req_ready=0 throughout. Repeat with rst asserted during the 2nd clear cycle -> outputs reset, no clr_done.
